jtpopeye_romarb: RTL and testbench



---
 rtl/jtpopeye_romarb_if.sv | 31 +++
 rtl/jtpopeye_romarb.sv | 207 ++++++++++++++++++++
 tb/tb_jtpopeye_romarb.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtpopeye_romarb_if.sv
// Slot request bus and SDRAM read bus of the Popeye ROM arbiter.
// slave is the arbiter side, master is the fetch logic / SDRAM controller side.
interface jtpopeye_romarb_if;
   logic [21:0] slot0_addr;
   logic        slot0_cs;
   logic        slot0_ok;
   logic [31:0] slot0_dout;
   logic [21:0] slot1_addr;
   logic        slot1_cs;
   logic        slot1_ok;
   logic [31:0] slot1_dout;
   logic [21:0] slot2_addr;
   logic        slot2_cs;
   logic        slot2_ok;
   logic [31:0] slot2_dout;
   logic        sdram_re;
   logic [21:0] sdram_addr;
   logic [31:0] data_read;

   modport slave (
      input  slot0_addr, slot0_cs, slot1_addr, slot1_cs, slot2_addr, slot2_cs, data_read,
      output slot0_ok, slot0_dout, slot1_ok, slot1_dout, slot2_ok, slot2_dout,
      output sdram_re, sdram_addr
   );

   modport master (
      output slot0_addr, slot0_cs, slot1_addr, slot1_cs, slot2_addr, slot2_cs, data_read,
      input  slot0_ok, slot0_dout, slot1_ok, slot1_dout, slot2_ok, slot2_dout,
      input  sdram_re, sdram_addr
   );
endinterface

// File: rtl/jtpopeye_romarb.sv
// Three-slot ROM read arbiter with a one-line cache per slot in front of one SDRAM read port.
// Define JTPOPEYE_ROMARB_RR_EN for round-robin arbitration; default is fixed priority 0>1>2.
module jtpopeye_romarb #(
   parameter int unsigned LATENCY   = 2,
   parameter int unsigned READY_DLY = 15,
   parameter logic [21:0] OFFSET1   = 22'h4000,
   parameter logic [21:0] OFFSET2   = 22'h6000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic cen,
   input  logic downloading,
   input  logic loop_rst,
   output logic ready,
   jtpopeye_romarb_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      CAPTURE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [1:0]  gsel_q, gsel_d;
   logic [21:0] gaddr_q, gaddr_d;
   logic        re_q, re_d;
   logic [21:0] addr_q, addr_d;
   logic [3:0]  rdy_cnt_q, rdy_cnt_d;
   logic        ready_q, ready_d;
   logic [2:0]  valid_q, valid_d;
   logic [21:0] tag_q [3];
   logic [21:0] tag_d [3];
   logic [31:0] data_q [3];
   logic [31:0] data_d [3];
`ifdef JTPOPEYE_ROMARB_RR_EN
   logic [1:0]  last_q, last_d;
`endif

   logic [21:0] slot_addr [3];
   logic [2:0]  slot_cs;
   logic [2:0]  slot_ok;
   logic [2:0]  pend;
   logic [1:0]  win;
   logic [21:0] win_addr;
   logic [21:0] win_off;
   logic        hold;

   assign slot_addr[0] = bus.slot0_addr;
   assign slot_addr[1] = bus.slot1_addr;
   assign slot_addr[2] = bus.slot2_addr;
   assign slot_cs      = {bus.slot2_cs, bus.slot1_cs, bus.slot0_cs};
   assign hold         = downloading | loop_rst;

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         slot_ok[i] = slot_cs[i] & valid_q[i] & (tag_q[i] == slot_addr[i]);
      end
   end

   assign pend = slot_cs & ~slot_ok & {3{ready_q}};

   // Winner is only meaningful when |pend; the search order depends on the build option.
   always_comb begin
`ifdef JTPOPEYE_ROMARB_RR_EN
      case (last_q)
         2'd0:    win = pend[1] ? 2'd1 : (pend[2] ? 2'd2 : 2'd0);
         2'd1:    win = pend[2] ? 2'd2 : (pend[0] ? 2'd0 : 2'd1);
         default: win = pend[0] ? 2'd0 : (pend[1] ? 2'd1 : 2'd2);
      endcase
`else
      win = pend[0] ? 2'd0 : (pend[1] ? 2'd1 : 2'd2);
`endif
   end

   always_comb begin
      case (win)
         2'd1: begin
            win_addr = slot_addr[1];
            win_off  = OFFSET1;
         end
         2'd2: begin
            win_addr = slot_addr[2];
            win_off  = OFFSET2;
         end
         default: begin
            win_addr = slot_addr[0];
            win_off  = 22'd0;
         end
      endcase
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      gsel_d    = gsel_q;
      gaddr_d   = gaddr_q;
      re_d      = re_q;
      addr_d    = addr_q;
      rdy_cnt_d = rdy_cnt_q;
      ready_d   = ready_q;
      valid_d   = valid_q;
      tag_d     = tag_q;
      data_d    = data_q;
`ifdef JTPOPEYE_ROMARB_RR_EN
      last_d    = last_q;
`endif
      // Soft reset drops any read in flight but keeps the last data on dout.
      if (hold) begin
         state_d   = IDLE;
         cnt_d     = 3'd0;
         re_d      = 1'b0;
         addr_d    = 22'd0;
         rdy_cnt_d = 4'd0;
         ready_d   = 1'b0;
         valid_d   = 3'b000;
`ifdef JTPOPEYE_ROMARB_RR_EN
         last_d    = 2'd2;
`endif
      end else if (cen) begin
         if (!ready_q) begin
            rdy_cnt_d = rdy_cnt_q + 4'd1;
            if (rdy_cnt_q == 4'(READY_DLY - 1)) begin
               ready_d = 1'b1;
            end
         end
         case (state_q)
            IDLE: begin
               if (|pend) begin
                  gsel_d  = win;
                  gaddr_d = win_addr;
                  addr_d  = win_addr + win_off;
                  re_d    = ~re_q;
                  cnt_d   = 3'(LATENCY);
                  state_d = WAIT;
`ifdef JTPOPEYE_ROMARB_RR_EN
                  last_d  = win;
`endif
               end
            end
            WAIT: begin
               cnt_d = cnt_q - 3'd1;
               if (cnt_q == 3'd1) begin
                  state_d = CAPTURE;
               end
            end
            CAPTURE: begin
               for (int i = 0; i < 3; i++) begin
                  if (gsel_q == 2'(i)) begin
                     data_d[i]  = bus.data_read;
                     tag_d[i]   = gaddr_q;
                     valid_d[i] = 1'b1;
                  end
               end
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= 3'd0;
         gsel_q    <= 2'd0;
         gaddr_q   <= 22'd0;
         re_q      <= 1'b0;
         addr_q    <= 22'd0;
         rdy_cnt_q <= 4'd0;
         ready_q   <= 1'b0;
         valid_q   <= 3'b000;
         tag_q     <= '{default: 22'd0};
         data_q    <= '{default: 32'd0};
`ifdef JTPOPEYE_ROMARB_RR_EN
         last_q    <= 2'd2;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         gsel_q    <= gsel_d;
         gaddr_q   <= gaddr_d;
         re_q      <= re_d;
         addr_q    <= addr_d;
         rdy_cnt_q <= rdy_cnt_d;
         ready_q   <= ready_d;
         valid_q   <= valid_d;
         tag_q     <= tag_d;
         data_q    <= data_d;
`ifdef JTPOPEYE_ROMARB_RR_EN
         last_q    <= last_d;
`endif
      end
   end

   assign ready          = ready_q;
   assign bus.sdram_re   = re_q;
   assign bus.sdram_addr = addr_q;
   assign bus.slot0_ok   = slot_ok[0];
   assign bus.slot1_ok   = slot_ok[1];
   assign bus.slot2_ok   = slot_ok[2];
   assign bus.slot0_dout = data_q[0];
   assign bus.slot1_dout = data_q[1];
   assign bus.slot2_dout = data_q[2];

endmodule

// File: tb/tb_jtpopeye_romarb.sv
// Self-checking bench for jtpopeye_romarb: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a transaction-level model of the arbiter.
module tb_jtpopeye_romarb;

   localparam int unsigned LATENCY   = 2;
   localparam int unsigned READY_DLY = 15;
   localparam logic [21:0] OFFSET1   = 22'h4000;
   localparam logic [21:0] OFFSET2   = 22'h6000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cen;
   logic        downloading;
   logic        loop_rst;
   logic        ready;
   logic [21:0] tb_addr [3];
   logic [2:0]  tb_cs;
   logic        use_fixed;
   logic [31:0] fixed_val;
   logic        checking = 1'b0;
   int          checks = 0;
   int          errors = 0;
   int          re_edges = 0;
   int          e0;

   jtpopeye_romarb_if bus ();

   assign bus.slot0_addr = tb_addr[0];
   assign bus.slot1_addr = tb_addr[1];
   assign bus.slot2_addr = tb_addr[2];
   assign bus.slot0_cs   = tb_cs[0];
   assign bus.slot1_cs   = tb_cs[1];
   assign bus.slot2_cs   = tb_cs[2];

   logic [2:0]  dut_ok;
   logic [31:0] dut_dout [3];
   assign dut_ok      = {bus.slot2_ok, bus.slot1_ok, bus.slot0_ok};
   assign dut_dout[0] = bus.slot0_dout;
   assign dut_dout[1] = bus.slot1_dout;
   assign dut_dout[2] = bus.slot2_dout;

   jtpopeye_romarb #(
      .LATENCY  (LATENCY),
      .READY_DLY(READY_DLY),
      .OFFSET1  (OFFSET1),
      .OFFSET2  (OFFSET2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cen        (cen),
      .downloading(downloading),
      .loop_rst   (loop_rst),
      .ready      (ready),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   always @(bus.sdram_re) re_edges++;

   // SDRAM contents as a pure function of the word address.
   function automatic logic [31:0] mem(input logic [21:0] a);
      return use_fixed ? fixed_val : ({a[9:0], a} ^ 32'h5A3C_96E1);
   endfunction

   // SDRAM side: data only becomes valid LATENCY cen ticks after a strobe edge.
   logic re_seen;
   int   since;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         re_seen <= 1'b0;
         since   <= 7;
      end else if (cen) begin
         if (bus.sdram_re != re_seen) begin
            re_seen <= bus.sdram_re;
            since   <= 1;
         end else if (since < 7) begin
            since <= since + 1;
         end
      end
   end
   assign bus.data_read = (since >= int'(LATENCY)) ? mem(bus.sdram_addr) : 32'hBAD0_BAD0;

   // Transaction-level reference: a read occupies the port for LATENCY+1 ticks after its grant.
   logic        m_ready;
   int          m_rcnt;
   logic [2:0]  m_valid;
   logic [21:0] m_tag [3];
   logic [31:0] m_data [3];
   logic        m_busy;
   int          m_slot;
   int          m_left;
   logic [21:0] m_gaddr;
   logic        m_re;
   logic [21:0] m_addr;
   int          m_last;
   int          mw;
   logic [2:0]  mpend;

   function automatic logic [21:0] slot_off(input int s);
      return (s == 1) ? OFFSET1 : ((s == 2) ? OFFSET2 : 22'd0);
   endfunction

   function automatic logic model_ok(input int s);
      return tb_cs[s] && m_valid[s] && (m_tag[s] == tb_addr[s]);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ready = 1'b0; m_rcnt = 0; m_valid = 3'b000; m_busy = 1'b0;
         m_re = 1'b0; m_addr = 22'd0; m_last = 2;
         for (int s = 0; s < 3; s++) begin
            m_data[s] = 32'd0;
            m_tag[s]  = 22'd0;
         end
      end else if (downloading || loop_rst) begin
         m_ready = 1'b0; m_rcnt = 0; m_valid = 3'b000; m_busy = 1'b0;
         m_re = 1'b0; m_addr = 22'd0; m_last = 2;
      end else if (cen) begin
         for (int s = 0; s < 3; s++) mpend[s] = m_ready && tb_cs[s] && !model_ok(s);
         if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
               m_busy          = 1'b0;
               m_data[m_slot]  = mem(m_addr);
               m_tag[m_slot]   = m_gaddr;
               m_valid[m_slot] = 1'b1;
            end
         end else begin
            mw = -1;
`ifdef JTPOPEYE_ROMARB_RR_EN
            for (int k = 1; k <= 3; k++) begin
               if (mw < 0 && mpend[(m_last + k) % 3]) mw = (m_last + k) % 3;
            end
`else
            for (int s = 0; s < 3; s++) begin
               if (mw < 0 && mpend[s]) mw = s;
            end
`endif
            if (mw >= 0) begin
               m_busy  = 1'b1;
               m_slot  = mw;
               m_gaddr = tb_addr[mw];
               m_left  = LATENCY + 1;
               m_re    = !m_re;
               m_addr  = tb_addr[mw] + slot_off(mw);
               m_last  = mw;
            end
         end
         if (!m_ready) begin
            m_rcnt++;
            if (m_rcnt == READY_DLY) m_ready = 1'b1;
         end
      end
   end

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (checking) begin
         check_output("ready", 32'(ready), 32'(m_ready));
         for (int s = 0; s < 3; s++) begin
            check_output($sformatf("ok%0d", s), 32'(dut_ok[s]), 32'(model_ok(s)));
            check_output($sformatf("dout%0d", s), dut_dout[s], m_data[s]);
         end
         check_output("sdram_re", 32'(bus.sdram_re), 32'(m_re));
         check_output("sdram_addr", 32'(bus.sdram_addr), 32'(m_addr));
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic apply_stimulus();
      logic [21:0] base;
      cen         = ($urandom_range(0, 3) != 0);
      downloading = ($urandom_range(0, 399) == 0);
      loop_rst    = ($urandom_range(0, 399) == 0);
      for (int s = 0; s < 3; s++) begin
         base = (s == 0) ? 22'h000100 : ((s == 1) ? 22'h000200 : 22'h3FFFFE);
         if ($urandom_range(0, 5) == 0) tb_cs[s] = ~tb_cs[s];
         if ($urandom_range(0, 9) == 0) tb_addr[s] = base + 22'($urandom_range(0, 3));
      end
   endtask

   initial begin
      rst_n = 1'b1; cen = 1'b0; downloading = 1'b1; loop_rst = 1'b0;
      tb_cs = 3'b000; tb_addr[0] = 22'd0; tb_addr[1] = 22'd0; tb_addr[2] = 22'd0;
      use_fixed = 1'b1; fixed_val = 32'hDEADBEEF;
      #2 rst_n = 1'b0;
      #1 checking = 1'b1;
      tick(2);
      check_output("reset_ready", 32'(ready), 32'd0);
      check_output("reset_re", 32'(bus.sdram_re), 32'd0);
      rst_n = 1'b1; cen = 1'b1;

      // Ready rises exactly READY_DLY ticks after download ends.
      tick(10);
      downloading = 1'b0;
      tick(14);
      check_output("ready_early", 32'(ready), 32'd0);
      tick(1);
      check_output("ready_on_time", 32'(ready), 32'd1);

      // Single miss on slot 0.
      tb_cs = 3'b001; tb_addr[0] = 22'h00123;
      e0 = re_edges;
      tick(1);
      check_output("t2_addr", 32'(bus.sdram_addr), 32'h00123);
      tick(2);
      check_output("t2_ok_early", 32'(dut_ok[0]), 32'd0);
      tick(1);
      check_output("t2_ok", 32'(dut_ok[0]), 32'd1);
      check_output("t2_dout", dut_dout[0], 32'hDEADBEEF);
      tick(5);
      check_output("t2_edges", 32'(re_edges - e0), 32'd1);

      // Slot 1 offset.
      tb_cs = 3'b010; tb_addr[1] = 22'h00010;
      tick(1);
      check_output("t3_addr", 32'(bus.sdram_addr), 32'h04010);
      tick(3);
      check_output("t3_ok", 32'(dut_ok[1]), 32'd1);

      // Three simultaneous misses, serviced 0,1,2.
      tb_addr[0] = 22'h200; tb_addr[1] = 22'h300; tb_addr[2] = 22'h400; tb_cs = 3'b111;
      e0 = re_edges;
      tick(1);
      check_output("t4_grant0", 32'(bus.sdram_addr), 32'h00200);
      tick(4);
      check_output("t4_grant1", 32'(bus.sdram_addr), 32'h04300);
      tick(4);
      check_output("t4_grant2", 32'(bus.sdram_addr), 32'h06400);
      tick(2);
      check_output("t4_ok11", 32'(dut_ok), 32'b011);
      tick(1);
      check_output("t4_ok12", 32'(dut_ok), 32'b111);
      check_output("t4_edges", 32'(re_edges - e0), 32'd3);

`ifdef JTPOPEYE_ROMARB_RR_EN
      // Slot 0 re-misses right after its fill; round-robin still reaches 1 and 2 first.
      tb_addr[0] = 22'h210; tb_addr[1] = 22'h310; tb_addr[2] = 22'h410;
      for (int t = 1; t <= 13; t++) begin
         tick(1);
         if (t == 1) check_output("rr_grant0", 32'(bus.sdram_addr), 32'h00210);
         if (t == 4) tb_addr[0] = 22'h211;
         if (t == 5) check_output("rr_grant1", 32'(bus.sdram_addr), 32'h04310);
         if (t == 9) check_output("rr_grant2", 32'(bus.sdram_addr), 32'h06410);
         if (t == 13) check_output("rr_grant3", 32'(bus.sdram_addr), 32'h00211);
      end
      tick(4);
`endif
      if (bus.sdram_re) begin
         tb_cs = 3'b010; tb_addr[1] = 22'h777;
         tick(6);
      end

      // Address change while the read is in flight.
      tb_cs = 3'b100; tb_addr[2] = 22'h100;
      e0 = re_edges;
      tick(1);
      check_output("t5_first", 32'(bus.sdram_addr), 32'h06100);
      tick(1);
      tb_addr[2] = 22'h101;
      tick(2);
      check_output("t5_stale_ok", 32'(dut_ok[2]), 32'd0);
      tick(1);
      check_output("t5_second", 32'(bus.sdram_addr), 32'h06101);
      tick(3);
      check_output("t5_ok", 32'(dut_ok[2]), 32'd1);
      check_output("t5_edges", 32'(re_edges - e0), 32'd2);

      // Soft reset in the middle of a read.
      tb_cs = 3'b001; tb_addr[0] = 22'h500;
      tick(1);
      check_output("t6_re_up", 32'(bus.sdram_re), 32'd1);
      tick(1);
      loop_rst = 1'b1;
      tick(1);
      loop_rst = 1'b0;
      check_output("t6_ready", 32'(ready), 32'd0);
      check_output("t6_re", 32'(bus.sdram_re), 32'd0);
      check_output("t6_ok", 32'(dut_ok[0]), 32'd0);
      check_output("t6_dout", dut_dout[0], 32'hDEADBEEF);
      tick(LATENCY + 2);
      check_output("t6_no_capture", 32'(dut_ok[0]), 32'd0);
      tick(20);

      use_fixed = 1'b0;
      for (int it = 0; it < 4000; it++) begin
         if (it == 2000) begin
            rst_n = 1'b0;
            tick(2);
            rst_n = 1'b1;
         end
         apply_stimulus();
         tick(1);
      end
      downloading = 1'b0; loop_rst = 1'b0;
      tick(2);
      checking = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
